// File: rtl/alarm_set_pkg.sv
// Shared types and BCD helpers for the front-panel alarm/time entry controller.
// Working values are kept as packed BCD digit pairs: hours {tens[1:0],units[3:0]}, minutes {tens[2:0],units[3:0]}.
package alarm_set_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT_H = 2'd1,
    EDIT_M = 2'd2,
    COMMIT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FIELD_NONE  = 2'd0,
    FIELD_HOURS = 2'd1,
    FIELD_MINS  = 2'd2
  } field_t;

  localparam logic [7:0] HOUR_MAX_BCD = 8'h23;
  localparam logic [6:0] MIN_MAX_BCD  = 7'h59;

  // Anything at or beyond the top value (including junk seeds like 25 or 61) wraps to 00.
  function automatic logic [5:0] next_hours(input logic [5:0] h);
    if ({2'b00, h} >= HOUR_MAX_BCD) return 6'h00;
    if (h[3:0] >= 4'd9)             return {h[5:4] + 2'd1, 4'd0};
    return {h[5:4], h[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] next_minutes(input logic [6:0] m);
    if (m >= MIN_MAX_BCD) return 7'h00;
    if (m[3:0] >= 4'd9)   return {m[6:4] + 3'd1, 4'd0};
    return {m[6:4], m[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detector with hold-to-repeat: 'rise' on the press, then 'step' after REPEAT_DLY
// cycles held and every REPEAT_RATE cycles after that until release.
module btn_repeat #(
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_RATE = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic rise,
  output logic step
);

  localparam int CMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DLY_C  = CW'(REPEAT_DLY);
  localparam logic [CW-1:0] RATE_C = CW'(REPEAT_RATE);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic          prev;
  logic          armed;
  logic          held;
  logic          repeating;
  logic [CW-1:0] cnt;

  // 'armed' masks the first cycle after reset so a button already down gives no edge.
  assign rise = level & ~prev & armed;
  assign step = held & level & (cnt == (repeating ? RATE_C : DLY_C));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev      <= 1'b0;
      armed     <= 1'b0;
      held      <= 1'b0;
      repeating <= 1'b0;
      cnt       <= '0;
    end else begin
      prev  <= level;
      armed <= 1'b1;
      if (rise) begin
        held      <= 1'b1;
        repeating <= 1'b0;
        cnt       <= ONE_C;
      end else if (!level) begin
        held      <= 1'b0;
        repeating <= 1'b0;
        cnt       <= '0;
      end else if (held) begin
        if (step) begin
          repeating <= 1'b1;
          cnt       <= ONE_C;
        end else begin
          cnt <= cnt + ONE_C;
        end
      end
    end
  end

endmodule

// File: rtl/alarm_time_setter.sv
// Button-driven HH:MM edit session seeded from the running clock, ending in one load strobe
// to either the time or the alarm register of alarm_clock.
module alarm_time_setter
  import alarm_set_pkg::*;
#(
  parameter int LD_HOLD     = 1,
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_RATE = 10,
  parameter int IDLE_TMO    = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_cancel,
  input  logic       sel_alarm,
  input  logic [1:0] cur_H1,
  input  logic [3:0] cur_H0,
  input  logic [2:0] cur_M1,
  input  logic [3:0] cur_M0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [2:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       editing,
  output logic [1:0] field
);

  localparam int TW = $clog2(IDLE_TMO + 1);
  localparam int HW = $clog2(LD_HOLD + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(IDLE_TMO - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LD_HOLD - 1);

  state_t        state, state_nx;
  logic          mode_prev, cancel_prev, armed;
  logic          mode_rise, cancel_rise, inc_rise, inc_step;
  logic          do_inc, activity, in_edit, timeout, hold_done;
  logic          tgt;
  logic [TW-1:0] tmo_cnt;
  logic [HW-1:0] hold_cnt;

  btn_repeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_RATE(REPEAT_RATE)
  ) u_inc (
    .clk    (clk),
    .reset_n(reset_n),
    .level  (btn_inc),
    .rise   (inc_rise),
    .step   (inc_step)
  );

  assign mode_rise   = btn_mode & ~mode_prev & armed;
  assign cancel_rise = btn_cancel & ~cancel_prev & armed;
  assign activity    = mode_rise | cancel_rise | inc_rise | inc_step;
  assign in_edit     = (state == EDIT_H) || (state == EDIT_M);
  assign timeout     = in_edit & ~activity & (tmo_cnt == TMO_LAST);
  assign hold_done   = (hold_cnt == HOLD_LAST);
  // cancel > mode > inc: an increment landing with either other edge is discarded.
  assign do_inc      = (inc_rise | inc_step) & ~mode_rise & ~cancel_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      mode_prev   <= 1'b0;
      cancel_prev <= 1'b0;
      armed       <= 1'b0;
      tmo_cnt     <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nx;
      mode_prev   <= btn_mode;
      cancel_prev <= btn_cancel;
      armed       <= 1'b1;
      tmo_cnt     <= (!in_edit || activity) ? '0 : tmo_cnt + TW'(1);
      hold_cnt    <= (state != COMMIT) ? '0 : hold_cnt + HW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (mode_rise) state_nx = EDIT_H;
      EDIT_H:  if (cancel_rise || timeout) state_nx = IDLE;
               else if (mode_rise)         state_nx = EDIT_M;
      EDIT_M:  if (cancel_rise || timeout) state_nx = IDLE;
               else if (mode_rise)         state_nx = COMMIT;
      COMMIT:  if (hold_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Working digits are held after the session so alarm_clock sees stable values around the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      H_in1 <= '0;
      H_in0 <= '0;
      M_in1 <= '0;
      M_in0 <= '0;
      tgt   <= 1'b0;
    end else if (state == IDLE && mode_rise) begin
      H_in1 <= cur_H1;
      H_in0 <= cur_H0;
      M_in1 <= cur_M1;
      M_in0 <= cur_M0;
      tgt   <= sel_alarm;
    end else if (state == EDIT_H && do_inc) begin
      {H_in1, H_in0} <= next_hours({H_in1, H_in0});
    end else if (state == EDIT_M && do_inc) begin
      {M_in1, M_in0} <= next_minutes({M_in1, M_in0});
    end
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    editing  = 1'b0;
    field    = FIELD_NONE;
    LD_time  = 1'b0;
    LD_alarm = 1'b0;
    case (state)
      EDIT_H: begin
        editing = 1'b1;
        field   = FIELD_HOURS;
      end
      EDIT_M: begin
        editing = 1'b1;
        field   = FIELD_MINS;
      end
      COMMIT: begin
        editing  = 1'b1;
        LD_time  = ~tgt;
        LD_alarm = tgt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alarm_time_setter.sv
// Directed scenarios plus random button traffic, checked every cycle against an integer-level
// model of the edit session (decimal hours/minutes, cycle ages for repeat and timeout).
module tb_alarm_time_setter;

  localparam int LD_HOLD = 4;
  localparam int DLY     = 50;
  localparam int RATE    = 10;
  localparam int TMO     = 1000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_cancel = 1'b0, sel_alarm = 1'b0;
  logic [1:0] cur_H1 = '0;
  logic [3:0] cur_H0 = '0;
  logic [2:0] cur_M1 = '0;
  logic [3:0] cur_M0 = '0;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [2:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time, LD_alarm, editing;
  logic [1:0] field;

  alarm_time_setter #(
    .LD_HOLD    (LD_HOLD),
    .REPEAT_DLY (DLY),
    .REPEAT_RATE(RATE),
    .IDLE_TMO   (TMO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .btn_cancel(btn_cancel),
    .sel_alarm (sel_alarm),
    .cur_H1    (cur_H1),
    .cur_H0    (cur_H0),
    .cur_M1    (cur_M1),
    .cur_M0    (cur_M0),
    .H_in1     (H_in1),
    .H_in0     (H_in0),
    .M_in1     (M_in1),
    .M_in0     (M_in0),
    .LD_time   (LD_time),
    .LD_alarm  (LD_alarm),
    .editing   (editing),
    .field     (field)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 hours, 2 minutes, 3 committing.
  int m_phase, m_hr, m_mn, m_age, m_quiet, m_left;
  bit m_tgt, m_pm, m_pc, m_pi, m_armed;

  int ld_t_cyc, ld_a_cyc, ld_t_rise, ld_a_rise;
  bit ld_t_prev, ld_a_prev;

  task automatic model_reset();
    m_phase = 0; m_hr = 0; m_mn = 0; m_age = -1; m_quiet = 0; m_left = 0;
    m_tgt = 0; m_pm = 0; m_pc = 0; m_pi = 0; m_armed = 0;
  endtask

  task automatic model_step();
    bit mr, cr, ir, st;
    mr = btn_mode && !m_pm && m_armed;
    cr = btn_cancel && !m_pc && m_armed;
    ir = btn_inc && !m_pi && m_armed;
    st = 0;
    if (ir) m_age = 0;
    else if (btn_inc && m_age >= 0) begin
      m_age++;
      st = (m_age >= DLY) && ((m_age - DLY) % RATE == 0);
    end else if (!btn_inc) m_age = -1;
    m_pm = btn_mode; m_pc = btn_cancel; m_pi = btn_inc; m_armed = 1;
    case (m_phase)
      0: if (mr) begin
        m_phase = 1;
        m_hr    = int'(cur_H1) * 10 + int'(cur_H0);
        m_mn    = int'(cur_M1) * 10 + int'(cur_M0);
        m_tgt   = sel_alarm;
        m_quiet = 0;
      end
      1, 2: begin
        if (cr) m_phase = 0;
        else if (mr) begin
          m_quiet = 0;
          if (m_phase == 2) begin m_phase = 3; m_left = LD_HOLD; end
          else m_phase = 2;
        end else if (ir || st) begin
          m_quiet = 0;
          if (m_phase == 1) m_hr = (m_hr >= 23) ? 0 : m_hr + 1;
          else              m_mn = (m_mn >= 59) ? 0 : m_mn + 1;
        end else begin
          m_quiet++;
          if (m_quiet == TMO) m_phase = 0;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) m_phase = 0;
      end
    endcase
  endtask

  function automatic logic [31:0] exp_outs();
    logic [1:0] f;
    f = (m_phase == 1) ? 2'd1 : (m_phase == 2) ? 2'd2 : 2'd0;
    return {14'b0, (m_phase == 3) && m_tgt, (m_phase == 3) && !m_tgt, m_phase != 0, f,
            2'(m_hr / 10), 4'(m_hr % 10), 3'(m_mn / 10), 4'(m_mn % 10)};
  endfunction

  function automatic logic [31:0] act_outs();
    return {14'b0, LD_alarm, LD_time, editing, field, H_in1, H_in0, M_in1, M_in0};
  endfunction

  function automatic logic [31:0] hm();
    return {19'b0, H_in1, H_in0, M_in1, M_in0};
  endfunction

  function automatic logic [31:0] hm_exp(input int h1, input int h0, input int m1, input int m0);
    return {19'b0, 2'(h1), 4'(h0), 3'(m1), 4'(m0)};
  endfunction

  task automatic clear_ld();
    ld_t_cyc = 0; ld_a_cyc = 0; ld_t_rise = 0; ld_a_rise = 0; ld_t_prev = 0; ld_a_prev = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("outs", act_outs(), exp_outs());
    if (LD_time)  begin ld_t_cyc++; if (!ld_t_prev) ld_t_rise++; end
    if (LD_alarm) begin ld_a_cyc++; if (!ld_a_prev) ld_a_rise++; end
    ld_t_prev = LD_time;
    ld_a_prev = LD_alarm;
  endtask

  task automatic press(input int which);
    case (which)
      0: btn_mode = 1'b1;
      1: btn_inc = 1'b1;
      default: btn_cancel = 1'b1;
    endcase
    tick();
    btn_mode = 1'b0; btn_inc = 1'b0; btn_cancel = 1'b0;
    tick();
  endtask

  task automatic set_cur(input int h1, input int h0, input int m1, input int m0);
    cur_H1 = 2'(h1); cur_H0 = 4'(h0); cur_M1 = 3'(m1); cur_M0 = 4'(m0);
  endtask

  task automatic do_reset();
    btn_mode = 0; btn_inc = 0; btn_cancel = 0;
    reset_n = 1'b0;
    model_reset();
    #3;
    check("rst_outs", act_outs(), exp_outs());
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    model_reset();
    clear_ld();
    do_reset();

    // Normal session into the time register: 05:02 -> 08:03.
    set_cur(0, 5, 0, 2); sel_alarm = 0; clear_ld();
    press(0);
    repeat (3) press(1);
    press(0);
    press(1);
    press(0);
    repeat (6) tick();
    check("t2_value", hm(), hm_exp(0, 8, 0, 3));
    check("t2_ld_cycles", ld_t_cyc, LD_HOLD);
    check("t2_ld_pulses", ld_t_rise, 1);
    check("t2_no_alarm", ld_a_cyc, 0);

    // Hours wrap, minutes wrap, other field untouched.
    set_cur(2, 2, 5, 9); clear_ld();
    press(0);
    repeat (2) press(1);
    check("t3_hours_wrap", hm(), hm_exp(0, 0, 5, 9));
    press(0);
    press(1);
    check("t3_min_wrap", hm(), hm_exp(0, 0, 0, 0));
    press(2);
    check("t3_cancel", editing, 0);

    // Auto-repeat over a 100-cycle hold from minute 00.
    set_cur(1, 2, 0, 0);
    press(0); press(0);
    btn_inc = 1'b1;
    repeat (100) tick();
    btn_inc = 1'b0;
    tick();
    check("t4_repeat", hm(), hm_exp(1, 2, 0, 6));
    press(2);

    // Out-of-range seed captured verbatim, first increment wraps to 00.
    set_cur(2, 5, 6, 1);
    press(0);
    check("seed_raw", hm(), hm_exp(2, 5, 6, 1));
    press(1);
    check("seed_hour_wrap", hm(), hm_exp(0, 0, 6, 1));
    press(0); press(1);
    check("seed_min_wrap", hm(), hm_exp(0, 0, 0, 0));
    press(2);
    check("t4_ld_none", ld_t_cyc + ld_a_cyc, 0);

    // Cancel, simultaneous mode+cancel, and idle timeout.
    clear_ld(); set_cur(1, 1, 1, 1);
    press(0); press(0); press(2);
    check("t5_cancel_m", {editing, field}, 3'b000);
    press(0);
    btn_mode = 1; btn_cancel = 1;
    tick();
    btn_mode = 0; btn_cancel = 0;
    tick();
    check("t5_mode_cancel", editing, 0);
    press(0);
    repeat (TMO - 2) tick();
    check("t5_pre_timeout", editing, 1);
    tick();
    check("t5_timeout", editing, 0);
    check("t5_ld_none", ld_t_cyc + ld_a_cyc, 0);

    // Target latched at session start.
    clear_ld(); sel_alarm = 1;
    press(0);
    sel_alarm = 0;
    press(0); press(0);
    repeat (6) tick();
    check("t6_alarm_cycles", ld_a_cyc, LD_HOLD);
    check("t6_time_none", ld_t_cyc, 0);

    // Reset dropped during the second strobe cycle.
    set_cur(1, 0, 1, 0); clear_ld();
    press(0); press(0);
    btn_mode = 1;
    tick();
    check("t1_ld_first", LD_time, 1);
    btn_mode = 0;
    tick();
    check("t1_ld_second", LD_time, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t1_ld_async", LD_time, 0);
    model_reset();
    check("t1_outs_zero", act_outs(), exp_outs());
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // A mode button held through reset release must not open a session.
    reset_n = 1'b0; btn_mode = 1'b1;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) tick();
    check("held_through_reset", editing, 0);
    btn_mode = 1'b0;
    tick();

    // Random traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      btn_mode   = ($urandom_range(0, 11) == 0);
      btn_cancel = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 24) == 0) btn_inc = ~btn_inc;
      if ($urandom_range(0, 49) == 0) sel_alarm = ~sel_alarm;
      set_cur($urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 7), $urandom_range(0, 9));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
